// File: rtl/median_window_engine_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | median_window_engine_pkg                                           |
// | Shared defaults and sort-cell select encoding.                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package median_window_engine_pkg;

  localparam int DEF_DATA_LENGTH = 32;
  localparam int DEF_WMAX        = 15;
  localparam int DEF_LOG_WMAX    = 4;

  typedef enum logic [1:0] {
    SEL_KEEP  = 2'd0,
    SEL_RIGHT = 2'd1,
    SEL_LEFT  = 2'd2,
    SEL_X     = 2'd3
  } cell_sel_e;

endpackage
`default_nettype wire

// File: rtl/median_sort_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | median_sort_cell                                                   |
// | One slot of the sorted array: delete/insert mux plus compares.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module median_sort_cell
  import median_window_engine_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_LENGTH,
  parameter bit SIGNED_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] left_val,
  input  logic [DATA_WIDTH-1:0] right_val,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] o,
  input  logic                  lt_d,
  input  logic                  lt_d_prev,
  input  logic                  lt_p,
  input  logic                  lt_p_prev,
  output logic [DATA_WIDTH-1:0] val,
  output logic                  x_lt,
  output logic                  o_eq
);

  // Flipping the sign bit turns a two's-complement compare into an unsigned one.
  localparam logic [DATA_WIDTH-1:0] BIAS = {SIGNED_DATA, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] val_q, val_d;
  cell_sel_e             sel;

  always_comb begin
    sel = SEL_KEEP;
    if (lt_p) begin
      sel = lt_d ? SEL_KEEP : SEL_RIGHT;
    end else if (lt_p_prev) begin
      sel = SEL_X;
    end else begin
      sel = lt_d_prev ? SEL_LEFT : SEL_KEEP;
    end

    val_d = val_q;
    if (en) begin
      case (sel)
        SEL_KEEP:  val_d = val_q;
        SEL_RIGHT: val_d = right_val;
        SEL_LEFT:  val_d = left_val;
        SEL_X:     val_d = x;
        default:   val_d = val_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val  = val_q;
  assign x_lt = (x ^ BIAS) < (val_q ^ BIAS);
  assign o_eq = (o == val_q);

endmodule
`default_nettype wire

// File: rtl/median_window_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | median_window_engine                                               |
// | Streaming running-median over a runtime odd window W (1..WMAX).    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module median_window_engine
  import median_window_engine_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_LENGTH,
  parameter int WMAX        = DEF_WMAX,
  parameter int LOG_WMAX    = DEF_LOG_WMAX,
  parameter bit SIGNED_DATA = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_load,
  input  logic [LOG_WMAX-1:0]   cfg_w,
  output logic                  cfg_err,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LOG_WMAX-1:0]   fill_cnt
);

  localparam logic [DATA_WIDTH-1:0] BIAS     = {SIGNED_DATA, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [LOG_WMAX-1:0]   WMAX_W   = LOG_WMAX'(WMAX);
  localparam logic [LOG_WMAX-1:0]   LAST_PTR = LOG_WMAX'(WMAX - 1);

  logic [DATA_WIDTH-1:0] hist_q [WMAX];
  logic [DATA_WIDTH-1:0] hist_d [WMAX];
  logic [LOG_WMAX-1:0]   fill_q, fill_d, rd_q, rd_d, wr_q, wr_d, w_q, w_d;
  logic                  out_valid_q, out_valid_d, cfg_err_q, cfg_err_d;

  logic [DATA_WIDTH-1:0] s_val [WMAX];
  logic [WMAX-1:0]       x_lt, o_eq, lt_d, lt_p;
  logic [DATA_WIDTH-1:0] oldest;
  logic                  full, hs, accept, cfg_take, cfg_ok, o_le_x, seen;
  logic [LOG_WMAX-1:0]   le_cnt, ins_pos, mid;

  assign in_ready = !out_valid_q || out_ready;

  // Delete index d and insert position p, derived from the per-cell compare flags.
  always_comb begin
    full   = (fill_q == w_q);
    oldest = hist_q[rd_q];
    o_le_x = !((in_data ^ BIAS) < (oldest ^ BIAS));
    le_cnt = '0;
    seen   = 1'b0;
    lt_d   = '0;
    lt_p   = '0;
    for (int i = 0; i < WMAX; i++) begin
      if (LOG_WMAX'(i) < fill_q) begin
        if (!x_lt[i]) le_cnt = le_cnt + 1'b1;
        if (full && o_eq[i]) seen = 1'b1;
      end
      lt_d[i] = !seen;
    end
    // The deleted entry no longer counts toward the insert position.
    ins_pos = le_cnt - LOG_WMAX'(full && o_le_x);
    for (int i = 0; i < WMAX; i++) begin
      lt_p[i] = (LOG_WMAX'(i) < ins_pos);
    end
  end

  always_comb begin
    hs          = in_valid && in_ready;
    accept      = hs && !flush;
    cfg_take    = cfg_load && !hs;
    cfg_ok      = cfg_w[0] && (cfg_w <= WMAX_W);
    hist_d      = hist_q;
    fill_d      = fill_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    w_d         = w_q;
    cfg_err_d   = 1'b0;
    out_valid_d = out_valid_q && !out_ready;

    if (accept) begin
      hist_d[wr_q] = in_data;
      wr_d         = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
      if (full) begin
        rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
      end else begin
        fill_d = fill_q + 1'b1;
      end
      out_valid_d = full || ((fill_q + 1'b1) == w_q);
    end

    if (cfg_take && cfg_ok) w_d = cfg_w;
    if (cfg_take && !cfg_ok) cfg_err_d = 1'b1;

    if (flush || (cfg_take && cfg_ok)) begin
      fill_d      = '0;
      rd_d        = '0;
      wr_d        = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WMAX; i++) hist_q[i] <= '0;
      fill_q      <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      w_q         <= WMAX_W;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < WMAX; i++) hist_q[i] <= hist_d[i];
      fill_q      <= fill_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  for (genvar i = 0; i < WMAX; i++) begin : g_cell
    logic [DATA_WIDTH-1:0] left_val, right_val;
    logic                  lt_d_prev, lt_p_prev;

    if (i == 0) begin : g_first
      assign left_val  = '0;
      assign lt_d_prev = 1'b1;
      assign lt_p_prev = 1'b1;
    end else begin : g_inner
      assign left_val  = s_val[i-1];
      assign lt_d_prev = lt_d[i-1];
      assign lt_p_prev = lt_p[i-1];
    end

    if (i == WMAX - 1) begin : g_last
      assign right_val = '0;
    end else begin : g_right
      assign right_val = s_val[i+1];
    end

    median_sort_cell #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SIGNED_DATA (SIGNED_DATA)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .en        (accept),
      .left_val  (left_val),
      .right_val (right_val),
      .x         (in_data),
      .o         (oldest),
      .lt_d      (lt_d[i]),
      .lt_d_prev (lt_d_prev),
      .lt_p      (lt_p[i]),
      .lt_p_prev (lt_p_prev),
      .val       (s_val[i]),
      .x_lt      (x_lt[i]),
      .o_eq      (o_eq[i])
    );
  end

  assign mid       = (w_q - 1'b1) >> 1;
  assign out_data  = s_val[mid];
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
  assign fill_cnt  = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_median_window_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_median_window_engine                                            |
// | Directed and randomized bench with a sorted-queue median model.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_median_window_engine;

  localparam int DW = 32;
  localparam int WM = 15;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset, cfg_load, flush, in_valid, out_ready;
  logic [LW-1:0] cfg_w;
  logic [DW-1:0] in_data;
  logic [7:0]    s_in_data;
  logic          cfg_err, in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [LW-1:0] fill_cnt;
  logic          s_cfg_err, s_in_ready, s_out_valid;
  logic [7:0]    s_out_data;
  logic [LW-1:0] s_fill_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: window contents in arrival order.
  logic [DW-1:0] win_u [$];
  logic [7:0]    win_s [$];
  int            m_w;
  logic          m_valid;

  always #5 clk = ~clk;

  median_window_engine #(.DATA_WIDTH(DW), .WMAX(WM), .LOG_WMAX(LW), .SIGNED_DATA(1'b0)) u_dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_w(cfg_w), .cfg_err(cfg_err),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .fill_cnt(fill_cnt)
  );

  median_window_engine #(.DATA_WIDTH(8), .WMAX(WM), .LOG_WMAX(LW), .SIGNED_DATA(1'b1)) u_sdut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_w(cfg_w), .cfg_err(s_cfg_err),
    .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .fill_cnt(s_fill_cnt)
  );

  function automatic logic [DW-1:0] med_u();
    logic [DW-1:0] a [$];
    logic [DW-1:0] t;
    a = win_u;
    for (int i = 1; i < a.size(); i++)
      for (int j = i; j > 0; j--)
        if (a[j-1] > a[j]) begin t = a[j]; a[j] = a[j-1]; a[j-1] = t; end
    return a[(a.size() - 1) / 2];
  endfunction

  function automatic logic [7:0] med_s();
    logic [7:0] a [$];
    logic [7:0] t;
    a = win_s;
    for (int i = 1; i < a.size(); i++)
      for (int j = i; j > 0; j--)
        if ($signed(a[j-1]) > $signed(a[j])) begin t = a[j]; a[j] = a[j-1]; a[j-1] = t; end
    return a[(a.size() - 1) / 2];
  endfunction

  function automatic void model_push(input logic [DW-1:0] x, input logic [7:0] sx);
    win_u.push_back(x);
    win_s.push_back(sx);
    if (win_u.size() > m_w) begin
      void'(win_u.pop_front());
      void'(win_s.pop_front());
    end
    m_valid = (win_u.size() == m_w);
  endfunction

  function automatic void model_clear(input int w);
    m_w = w;
    win_u.delete();
    win_s.delete();
    m_valid = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] x);
    in_valid  = 1'b1;
    in_data   = x;
    s_in_data = x[7:0];
    tick();
    in_valid  = 1'b0;
    model_push(x, x[7:0]);
  endtask

  task automatic set_w(input int w);
    cfg_load = 1'b1;
    cfg_w    = LW'(w);
    tick();
    cfg_load = 1'b0;
    model_clear(w);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_clear(WM);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (fill_cnt !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_med [3] = '{32'd4, 32'd2, 32'd4};
    logic [DW-1:0] stim [5]    = '{32'd5, 32'd1, 32'd4, 32'd2, 32'd9};
    set_w(3);
    for (int k = 0; k < 5; k++) begin
      send(stim[k]);
      if (k < 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_warmup_valid[%0d]: got %b want 0", k, out_valid); end
        checks++; if (fill_cnt !== LW'(k + 1)) begin errors++; $display("FAIL basic_fill[%0d]: got %0d want %0d", k, fill_cnt, k + 1); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b want 1", k, out_valid); end
        checks++; if (out_data !== exp_med[k-2]) begin errors++; $display("FAIL basic_median[%0d]: got %0d want %0d", k, out_data, exp_med[k-2]); end
        checks++; if (fill_cnt !== 4'd3) begin errors++; $display("FAIL basic_fill_sat[%0d]: got %0d want 3", k, fill_cnt); end
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_duplicates();
    logic [DW-1:0] stim [5]    = '{32'd7, 32'd7, 32'd7, 32'd3, 32'd3};
    logic [DW-1:0] exp_med [3] = '{32'd7, 32'd7, 32'd3};
    set_w(3);
    for (int k = 0; k < 5; k++) begin
      send(stim[k]);
      if (k >= 2) begin
        checks++; if (out_data !== exp_med[k-2]) begin errors++; $display("FAIL dup_median[%0d]: got %0d want %0d", k, out_data, exp_med[k-2]); end
      end
    end
  endtask

  task automatic test_signed();
    set_w(3);
    send(32'hFF);
    send(32'h01);
    send(32'h02);
    checks++; if (out_data !== 32'h02) begin errors++; $display("FAIL unsigned_median: got %0h want 2", out_data); end
    checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h01) begin errors++; $display("FAIL signed_median: got v=%b %0h want v=1 01", s_out_valid, s_out_data); end
  endtask

  task automatic test_backpressure();
    set_w(3);
    send(32'd10);
    send(32'd20);
    send(32'd30);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd40;
    s_in_data = 8'd40;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'd20) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %0d want v=1 20", k, out_valid, out_data); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_data !== 32'd30) begin errors++; $display("FAIL bp_resume1: got %0d want 30", out_data); end
    in_valid = 1'b0;
    send(32'd50);
    checks++; if (out_data !== 32'd40 || fill_cnt !== 4'd3) begin errors++; $display("FAIL bp_resume2: got %0d fill %0d want 40 fill 3", out_data, fill_cnt); end
  endtask

  task automatic test_cfg();
    set_w(3);
    send(32'd1);
    send(32'd2);
    send(32'd3);
    cfg_load = 1'b1;
    cfg_w    = 4'd4;
    tick();
    cfg_load = 1'b0;
    checks++; if (cfg_err !== 1'b1 || fill_cnt !== 4'd3) begin errors++; $display("FAIL cfg_even_err: got err=%b fill=%0d want err=1 fill=3", cfg_err, fill_cnt); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err); end
    send(32'd4);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd3) begin errors++; $display("FAIL cfg_w_kept: got v=%b %0d want v=1 3", out_valid, out_data); end
    set_w(5);
    checks++; if (fill_cnt !== 4'd0 || out_valid !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_w5_flush: got fill=%0d v=%b err=%b want 0 0 0", fill_cnt, out_valid, cfg_err); end
    send(32'd9);
    send(32'd8);
    send(32'd7);
    send(32'd6);
    checks++; if (out_valid !== 1'b0 || fill_cnt !== 4'd4) begin errors++; $display("FAIL cfg_w5_warmup: got v=%b fill=%0d want v=0 fill=4", out_valid, fill_cnt); end
    send(32'd5);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd7) begin errors++; $display("FAIL cfg_w5_median: got v=%b %0d want v=1 7", out_valid, out_data); end
    set_w(1);
    send(32'd8);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd8) begin errors++; $display("FAIL cfg_w1_a: got v=%b %0d want v=1 8", out_valid, out_data); end
    send(32'd3);
    checks++; if (out_data !== 32'd3) begin errors++; $display("FAIL cfg_w1_b: got %0d want 3", out_data); end
    cfg_load = 1'b1;
    cfg_w    = 4'd5;
    send(32'd11);
    cfg_load = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd11 || fill_cnt !== 4'd1) begin errors++; $display("FAIL cfg_ignored: got v=%b %0d fill=%0d want v=1 11 fill=1", out_valid, out_data, fill_cnt); end
    send(32'd12);
    checks++; if (out_data !== 32'd12) begin errors++; $display("FAIL cfg_ignored_w: got %0d want 12", out_data); end
  endtask

  task automatic test_flush();
    set_w(3);
    send(32'd1);
    send(32'd2);
    send(32'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd100;
    s_in_data = 8'd100;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    model_clear(3);
    checks++; if (fill_cnt !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_state: got fill=%0d v=%b want 0 0", fill_cnt, out_valid); end
    send(32'd5);
    send(32'd6);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_warmup: got %b want 0", out_valid); end
    send(32'd7);
    checks++; if (out_data !== 32'd6) begin errors++; $display("FAIL flush_median: got %0d want 6", out_data); end
  endtask

  task automatic test_reset_midstream();
    set_w(3);
    send(32'd40);
    send(32'd50);
    send(32'd60);
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || fill_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_state: got v=%b fill=%0d want 0 0", out_valid, fill_cnt); end
    reset = 1'b1;
    model_clear(WM);
    for (int k = 0; k < WM - 1; k++) send($urandom);
    checks++; if (out_valid !== 1'b0 || fill_cnt !== LW'(WM - 1)) begin errors++; $display("FAIL rst_mid_wmax_warmup: got v=%b fill=%0d want v=0 fill=%0d", out_valid, fill_cnt, WM - 1); end
    send($urandom);
    checks++; if (out_valid !== 1'b1 || out_data !== med_u()) begin errors++; $display("FAIL rst_mid_wmax_median: got v=%b %0h want v=1 %0h", out_valid, out_data, med_u()); end
  endtask

  task automatic run_random(input int w, input int n);
    logic exp_ready;
    set_w(w);
    for (int c = 0; c < n; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = ($urandom_range(0, 1) == 1) ? $urandom : DW'($urandom_range(0, 7));
      s_in_data = 8'($urandom);
      #1;
      exp_ready = !m_valid || out_ready;
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready w=%0d c=%0d: got %b want %b", w, c, in_ready, exp_ready); end
      if (in_valid && exp_ready) model_push(in_data, s_in_data);
      else if (out_ready) m_valid = 1'b0;
      tick();
      checks++; if (out_valid !== m_valid || fill_cnt !== LW'(win_u.size())) begin errors++; $display("FAIL rnd_state w=%0d c=%0d: got v=%b fill=%0d want v=%b fill=%0d", w, c, out_valid, fill_cnt, m_valid, win_u.size()); end
      if (m_valid) begin
        checks++; if (out_data !== med_u()) begin errors++; $display("FAIL rnd_median w=%0d c=%0d: got %0h want %0h", w, c, out_data, med_u()); end
        checks++; if (s_out_data !== med_s()) begin errors++; $display("FAIL rnd_signed_median w=%0d c=%0d: got %0h want %0h", w, c, s_out_data, med_s()); end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    run_random(WM, 200);
    run_random(3, 150);
    run_random(1, 60);
    run_random(7, 150);
  endtask

  initial begin
    reset     = 1'b0;
    cfg_load  = 1'b0;
    cfg_w     = '0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    s_in_data = '0;
    out_ready = 1'b1;
    m_w       = WM;
    m_valid   = 1'b0;
    test_reset();
    test_basic();
    test_duplicates();
    test_signed();
    test_backpressure();
    test_cfg();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
